// File: rtl/vdp_crtc.sv
// rtl/vdp_crtc.sv - CPU-programmable video timing generator (CRTC)
//
// Purpose: generates pixel/line counters, display enable, polarity-programmable
// syncs, line/frame strobes and a maskable scanline/vblank interrupt from a
// register file loaded over a two-step (select, then data) CPU port.
//
// Ports:
//   clk_i          system clock
//   reset_i        synchronous, active-high reset
//   mode_i         0 = register-select access, 1 = register data access
//   write_i        CPU write strobe, commits on its falling edge
//   data_in_i      CPU write data
//   data_out_o     readback of the selected register (1-clock latency)
//   h_count_o      current pixel in line
//   v_count_o      current line in frame
//   de_o           display enable (registered)
//   hsync_o        horizontal sync, polarity applied
//   vsync_o        vertical sync, polarity applied
//   pixel_tick_o   one-clock pulse per pixel
//   line_start_o   pulse when h_count wraps to 0
//   frame_start_o  pulse when h_count and v_count both wrap to 0
//   irq_o          level interrupt

module vdp_crtc #(
  parameter int CW      = 11,
  parameter int SW      = 8,
  parameter int PIX_DIV = 2
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          mode_i,
  input  logic          write_i,
  input  logic [7:0]    data_in_i,
  output logic [7:0]    data_out_o,
  output logic [CW-1:0] h_count_o,
  output logic [CW-1:0] v_count_o,
  output logic          de_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          pixel_tick_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic          irq_o
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  localparam logic [CW-1:0] H_TOT_RST  = CW'(1087);
  localparam logic [CW-1:0] H_DISP_RST = CW'(847);
  localparam logic [CW-1:0] H_SS_RST   = CW'(863);
  localparam logic [SW-1:0] H_SL_RST   = SW'(111);
  localparam logic [CW-1:0] V_TOT_RST  = CW'(516);
  localparam logic [CW-1:0] V_DISP_RST = CW'(479);
  localparam logic [CW-1:0] V_SS_RST   = CW'(485);
  localparam logic [SW-1:0] V_SL_RST   = SW'(7);

  // CPU port
  logic          mode_q, mode_d, write_q, write_d;
  logic [7:0]    data_q, data_d, sel_q, sel_d, dout_q, dout_d;
  // timing registers (stored minus-one)
  logic [CW-1:0] h_tot_q, h_tot_d, h_disp_q, h_disp_d, h_ss_q, h_ss_d;
  logic [CW-1:0] v_tot_q, v_tot_d, v_disp_q, v_disp_d, v_ss_q, v_ss_d;
  logic [SW-1:0] h_sl_q, h_sl_d, v_sl_q, v_sl_d;
  logic [CW-1:0] lcmp_q, lcmp_d;
  logic          hpol_q, hpol_d, vpol_q, vpol_d, lien_q, lien_d;
  logic          fien_q, fien_d, en_q, en_d;
  logic          pl_q, pl_d, pf_q, pf_d, irq_q, irq_d;
  // timing state
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [SW:0]   hs_cnt_q, hs_cnt_d, vs_cnt_q, vs_cnt_d;
  logic          de_q, de_d, ls_q, ls_d, fs_q, fs_d;
  // set while disabled so the first tick after enabling emits the
  // frame/line strobes at pixel 0, line 0 instead of advancing
  logic          restart_q, restart_d;

  logic          commit, tick, in_vblank;
  logic          line_ev, frame_ev, set_line, set_frame, clr_line, clr_frame;
  logic [CW-1:0] h_nx, v_nx;

  function automatic logic [7:0] hi8(input logic [CW-1:0] x);
    return 8'(x >> 8);
  endfunction

  assign tick      = en_q && (div_q == DIV_LAST);
  assign in_vblank = v_q > v_disp_q;

  always_comb begin
    mode_d    = mode_i;
    write_d   = write_i;
    data_d    = data_in_i;
    sel_d     = sel_q;
    h_tot_d   = h_tot_q;
    h_disp_d  = h_disp_q;
    h_ss_d    = h_ss_q;
    h_sl_d    = h_sl_q;
    v_tot_d   = v_tot_q;
    v_disp_d  = v_disp_q;
    v_ss_d    = v_ss_q;
    v_sl_d    = v_sl_q;
    lcmp_d    = lcmp_q;
    hpol_d    = hpol_q;
    vpol_d    = vpol_q;
    lien_d    = lien_q;
    fien_d    = fien_q;
    en_d      = en_q;
    div_d     = div_q;
    h_d       = h_q;
    v_d       = v_q;
    hs_cnt_d  = hs_cnt_q;
    vs_cnt_d  = vs_cnt_q;
    de_d      = 1'b0;
    ls_d      = 1'b0;
    fs_d      = 1'b0;
    restart_d = restart_q;
    h_nx      = h_q;
    v_nx      = v_q;
    line_ev   = 1'b0;
    frame_ev  = 1'b0;
    set_line  = 1'b0;
    set_frame = 1'b0;
    clr_line  = 1'b0;
    clr_frame = 1'b0;

    // commit on the falling edge of the registered write strobe
    commit = write_q && !write_i;
    if (commit && !mode_q) begin
      sel_d = data_q;
    end else if (commit && mode_q) begin
      case (sel_q)
        8'd0:  h_tot_d[7:0]     = data_q;
        8'd1:  h_tot_d[CW-1:8]  = data_q[CW-9:0];
        8'd2:  h_disp_d[7:0]    = data_q;
        8'd3:  h_disp_d[CW-1:8] = data_q[CW-9:0];
        8'd4:  h_ss_d[7:0]      = data_q;
        8'd5:  h_ss_d[CW-1:8]   = data_q[CW-9:0];
        8'd6:  h_sl_d           = SW'(data_q);
        8'd7:  v_tot_d[7:0]     = data_q;
        8'd8:  v_tot_d[CW-1:8]  = data_q[CW-9:0];
        8'd9:  v_disp_d[7:0]    = data_q;
        8'd10: v_disp_d[CW-1:8] = data_q[CW-9:0];
        8'd11: v_ss_d[7:0]      = data_q;
        8'd12: v_ss_d[CW-1:8]   = data_q[CW-9:0];
        8'd13: v_sl_d           = SW'(data_q);
        8'd14: begin
          hpol_d = data_q[0];
          vpol_d = data_q[1];
          lien_d = data_q[2];
          fien_d = data_q[3];
          en_d   = data_q[7];
        end
        8'd15: lcmp_d[7:0]      = data_q;
        8'd16: lcmp_d[CW-1:8]   = data_q[CW-9:0];
        8'd17: begin
          clr_line  = data_q[0];
          clr_frame = data_q[1];
        end
        default: ;
      endcase
    end

    if (!en_q) begin
      div_d     = '0;
      h_d       = '0;
      v_d       = '0;
      hs_cnt_d  = '0;
      vs_cnt_d  = '0;
      restart_d = 1'b1;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      de_d  = (h_q <= h_disp_q) && (v_q <= v_disp_q);
      if (tick) begin
        if (restart_q) begin
          h_nx      = '0;
          v_nx      = '0;
          line_ev   = 1'b1;
          frame_ev  = 1'b1;
          restart_d = 1'b0;
        end else begin
          // >= so a total written below the current count wraps at once
          line_ev = h_q >= h_tot_q;
          h_nx    = line_ev ? '0 : h_q + 1'b1;
          if (line_ev) begin
            frame_ev = v_q >= v_tot_q;
            v_nx     = frame_ev ? '0 : v_q + 1'b1;
          end
        end
        h_d  = h_nx;
        v_d  = v_nx;
        ls_d = line_ev;
        fs_d = frame_ev;
        // sync down-counters: loaded with length+1 on reaching the start
        // position, so a sync can run across the wrap
        if (h_nx == h_ss_q) begin
          hs_cnt_d = {1'b0, h_sl_q} + 1'b1;
        end else if (hs_cnt_q != '0) begin
          hs_cnt_d = hs_cnt_q - 1'b1;
        end
        if (line_ev) begin
          if (v_nx == v_ss_q) begin
            vs_cnt_d = {1'b0, v_sl_q} + 1'b1;
          end else if (vs_cnt_q != '0) begin
            vs_cnt_d = vs_cnt_q - 1'b1;
          end
          set_line  = v_nx == lcmp_q;
          set_frame = v_nx == v_disp_q + 1'b1;
        end
      end
    end

    // a set in the same clock as a CPU clear wins
    pl_d  = set_line || (pl_q && !clr_line);
    pf_d  = set_frame || (pf_q && !clr_frame);
    irq_d = (pl_q && lien_q) || (pf_q && fien_q);

    case (sel_q)
      8'd0:  dout_d = h_tot_q[7:0];
      8'd1:  dout_d = hi8(h_tot_q);
      8'd2:  dout_d = h_disp_q[7:0];
      8'd3:  dout_d = hi8(h_disp_q);
      8'd4:  dout_d = h_ss_q[7:0];
      8'd5:  dout_d = hi8(h_ss_q);
      8'd6:  dout_d = 8'(h_sl_q);
      8'd7:  dout_d = v_tot_q[7:0];
      8'd8:  dout_d = hi8(v_tot_q);
      8'd9:  dout_d = v_disp_q[7:0];
      8'd10: dout_d = hi8(v_disp_q);
      8'd11: dout_d = v_ss_q[7:0];
      8'd12: dout_d = hi8(v_ss_q);
      8'd13: dout_d = 8'(v_sl_q);
      8'd14: dout_d = {en_q, 3'b000, fien_q, lien_q, vpol_q, hpol_q};
      8'd15: dout_d = lcmp_q[7:0];
      8'd16: dout_d = hi8(lcmp_q);
      8'd17: dout_d = {5'b00000, in_vblank, pf_q, pl_q};
      default: dout_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mode_q    <= 1'b0;
      write_q   <= 1'b0;
      data_q    <= 8'h00;
      sel_q     <= 8'h00;
      dout_q    <= 8'h00;
      h_tot_q   <= H_TOT_RST;
      h_disp_q  <= H_DISP_RST;
      h_ss_q    <= H_SS_RST;
      h_sl_q    <= H_SL_RST;
      v_tot_q   <= V_TOT_RST;
      v_disp_q  <= V_DISP_RST;
      v_ss_q    <= V_SS_RST;
      v_sl_q    <= V_SL_RST;
      lcmp_q    <= '0;
      hpol_q    <= 1'b1;
      vpol_q    <= 1'b1;
      lien_q    <= 1'b0;
      fien_q    <= 1'b0;
      en_q      <= 1'b1;
      pl_q      <= 1'b0;
      pf_q      <= 1'b0;
      irq_q     <= 1'b0;
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      hs_cnt_q  <= '0;
      vs_cnt_q  <= '0;
      de_q      <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      write_q   <= write_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      dout_q    <= dout_d;
      h_tot_q   <= h_tot_d;
      h_disp_q  <= h_disp_d;
      h_ss_q    <= h_ss_d;
      h_sl_q    <= h_sl_d;
      v_tot_q   <= v_tot_d;
      v_disp_q  <= v_disp_d;
      v_ss_q    <= v_ss_d;
      v_sl_q    <= v_sl_d;
      lcmp_q    <= lcmp_d;
      hpol_q    <= hpol_d;
      vpol_q    <= vpol_d;
      lien_q    <= lien_d;
      fien_q    <= fien_d;
      en_q      <= en_d;
      pl_q      <= pl_d;
      pf_q      <= pf_d;
      irq_q     <= irq_d;
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      hs_cnt_q  <= hs_cnt_d;
      vs_cnt_q  <= vs_cnt_d;
      de_q      <= de_d;
      ls_q      <= ls_d;
      fs_q      <= fs_d;
      restart_q <= restart_d;
    end
  end

  assign data_out_o    = dout_q;
  assign h_count_o     = h_q;
  assign v_count_o     = v_q;
  assign de_o          = de_q;
  assign hsync_o       = hpol_q ? (hs_cnt_q != '0) : (hs_cnt_q == '0);
  assign vsync_o       = vpol_q ? (vs_cnt_q != '0) : (vs_cnt_q == '0);
  assign pixel_tick_o  = tick;
  assign line_start_o  = ls_q;
  assign frame_start_o = fs_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_vdp_crtc.sv
// tb/tb_vdp_crtc.sv - self-checking bench for vdp_crtc

module tb_vdp_crtc;

  logic        clk = 1'b0;
  logic        reset_i, mode_i, write_i;
  logic [7:0]  data_in_i, data_out_o;
  logic [10:0] h_count_o, v_count_o;
  logic        de_o, hsync_o, vsync_o, pixel_tick_o;
  logic        line_start_o, frame_start_o, irq_o;

  always #5 clk = ~clk;

  vdp_crtc dut (
    .clk_i(clk), .reset_i(reset_i), .mode_i(mode_i), .write_i(write_i),
    .data_in_i(data_in_i), .data_out_o(data_out_o),
    .h_count_o(h_count_o), .v_count_o(v_count_o), .de_o(de_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .pixel_tick_o(pixel_tick_o),
    .line_start_o(line_start_o), .frame_start_o(frame_start_o), .irq_o(irq_o)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int m_ls, m_fs, m_de, m_hs, m_vs, m_bad;

  task automatic expect_val(input string t, input logic [31:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic check_obs(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
    end
  endtask

  task automatic wr(input logic m, input logic [7:0] d);
    @(negedge clk);
    mode_i = m; data_in_i = d; write_i = 1'b1;
    @(negedge clk);
    write_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
    wr(1'b0, a);
    wr(1'b1, d);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string t);
    wr(1'b0, a);
    expect_val(t, 32'(e));
    @(negedge clk);
    check_obs(32'(data_out_o));
  endtask

  // one frame (80 clk with the small timing) starting at a frame_start
  task automatic measure(input int a, input int b, input int c);
    int n;
    n = 0;
    m_ls = 0; m_fs = 0; m_de = 0; m_hs = 0; m_vs = 0; m_bad = 0;
    while (frame_start_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    expect_val("frame_found", 1);
    check_obs(32'(n < 400));
    for (int i = 0; i < 80; i++) begin
      m_ls += int'(line_start_o);
      m_fs += int'(frame_start_o);
      m_de += int'(de_o);
      m_hs += int'(hsync_o);
      m_vs += int'(vsync_o);
      if (hsync_o && h_count_o != 11'(a) && h_count_o != 11'(b) && h_count_o != 11'(c))
        m_bad++;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;
    reset_i = 1'b1; mode_i = 1'b0; write_i = 1'b0; data_in_i = 8'h00;
    repeat (3) @(negedge clk);
    expect_val("rst_h_count", 0); check_obs(32'(h_count_o));
    expect_val("rst_de", 0);      check_obs(32'(de_o));
    expect_val("rst_hsync", 0);   check_obs(32'(hsync_o));
    expect_val("rst_vsync", 0);   check_obs(32'(vsync_o));
    expect_val("rst_irq", 0);     check_obs(32'(irq_o));
    reset_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_val("rd_htot_lo", 32'h3F); check_obs(32'(data_out_o));
    rd(8'd14, 8'h83, "rd_control");
    rd(8'd1, 8'd4, "rd_htot_hi");
    rd(8'd6, 8'd111, "rd_hsync_len");
    rd(8'd7, 8'd4, "rd_vtot_lo");
    rd(8'd20, 8'h00, "rd_unmapped");

    // disable, then program a small raster
    reg_wr(8'd14, 8'h03);
    reg_wr(8'd0, 8'd9);  reg_wr(8'd1, 8'd0);
    reg_wr(8'd2, 8'd5);  reg_wr(8'd3, 8'd0);
    reg_wr(8'd4, 8'd7);  reg_wr(8'd5, 8'd0);
    reg_wr(8'd6, 8'd1);
    reg_wr(8'd7, 8'd3);  reg_wr(8'd8, 8'd0);
    reg_wr(8'd9, 8'd1);  reg_wr(8'd10, 8'd0);
    reg_wr(8'd11, 8'd2); reg_wr(8'd12, 8'd0);
    reg_wr(8'd13, 8'd0);
    reg_wr(8'd15, 8'd2); reg_wr(8'd16, 8'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (h_count_o != 0 || v_count_o != 0 || de_o || line_start_o ||
          frame_start_o || pixel_tick_o)
        bad++;
      @(negedge clk);
    end
    expect_val("disabled_activity", 0); check_obs(32'(bad));

    // re-enable: frame_start on the first pixel tick
    reg_wr(8'd14, 8'h83);
    n = 0;
    while (frame_start_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    expect_val("enable_to_frame_start", 2); check_obs(32'(n));
    expect_val("enable_hv_zero", 0); check_obs(32'({h_count_o, v_count_o}));
    repeat (2) @(negedge clk);
    expect_val("enable_h_next", 1); check_obs(32'(h_count_o));

    measure(7, 8, 8);
    expect_val("line_starts", 4);  check_obs(32'(m_ls));
    expect_val("frame_starts", 1); check_obs(32'(m_fs));
    expect_val("de_clocks", 24);   check_obs(32'(m_de));
    expect_val("hsync_clocks", 16); check_obs(32'(m_hs));
    expect_val("vsync_clocks", 20); check_obs(32'(m_vs));
    expect_val("hsync_position", 0); check_obs(32'(m_bad));

    // hsync spanning the line wrap
    reg_wr(8'd4, 8'd9);
    reg_wr(8'd6, 8'd2);
    repeat (80) @(negedge clk);
    measure(9, 0, 1);
    expect_val("wrap_hsync_clocks", 24); check_obs(32'(m_hs));
    expect_val("wrap_hsync_position", 0); check_obs(32'(m_bad));
    reg_wr(8'd14, 8'h82);
    measure(9, 0, 1);
    expect_val("inverted_hsync_clocks", 56); check_obs(32'(m_hs));
    reg_wr(8'd14, 8'h87);

    // line interrupt
    n = 0;
    while (frame_start_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    expect_val("irq_frame_found", 1); check_obs(32'(n < 400));
    reg_wr(8'd17, 8'h03);
    @(negedge clk);
    expect_val("irq_after_clear", 0);    check_obs(32'(irq_o));
    expect_val("status_after_clear", 0); check_obs(32'(data_out_o));
    n = 0;
    while (!(line_start_o === 1'b1 && v_count_o == 11'd2) && n < 400) begin
      @(negedge clk);
      n++;
    end
    expect_val("line2_found", 1); check_obs(32'(n < 400));
    expect_val("irq_same_clk", 0); check_obs(32'(irq_o));
    @(negedge clk);
    expect_val("irq_rise", 1); check_obs(32'(irq_o));
    expect_val("status_line2", 7); check_obs(32'(data_out_o));
    wr(1'b1, 8'h01);
    @(negedge clk);
    expect_val("irq_cleared", 0); check_obs(32'(irq_o));
    expect_val("status_line_cleared", 6); check_obs(32'(data_out_o));

    // clear coinciding with a set: commit lands on the line-2 line_start
    n = 0;
    while (!(line_start_o === 1'b1 && v_count_o == 11'd1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    expect_val("line1_found", 1); check_obs(32'(n < 400));
    repeat (17) @(negedge clk);
    wr(1'b1, 8'h01);
    expect_val("collide_line_start", 1); check_obs(32'(line_start_o));
    expect_val("collide_v_count", 2);    check_obs(32'(v_count_o));
    @(negedge clk);
    expect_val("collide_pending", 1); check_obs(32'(data_out_o[0]));
    expect_val("collide_irq", 1);     check_obs(32'(irq_o));
    wr(1'b1, 8'h03);
    @(negedge clk);
    expect_val("irq_final_clear", 0); check_obs(32'(irq_o));
    reg_wr(8'd14, 8'h83);

    // shrink h_total below the running count
    wr(1'b0, 8'd0);
    n = 0;
    while (!(h_count_o == 11'd7 && pixel_tick_o === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    expect_val("h7_found", 1); check_obs(32'(n < 100));
    mode_i = 1'b1; data_in_i = 8'd3; write_i = 1'b1;
    @(negedge clk);
    write_i = 1'b0;
    @(negedge clk);
    expect_val("shrink_h_before", 8); check_obs(32'(h_count_o));
    @(negedge clk);
    expect_val("shrink_wrap_h", 0);   check_obs(32'(h_count_o));
    expect_val("shrink_wrap_ls", 1);  check_obs(32'(line_start_o));
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (line_start_o !== 1'b1 && n < 100);
      expect_val("short_line_clocks", 8); check_obs(32'(n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
